rps_referee: RTL

//  Parametrised referee for an N-way cyclic rock-paper-scissors match between two players.

---
 rtl/rps_referee_if.sv | 34 +++
 rtl/rps_referee.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/rps_referee_if.sv
// Referee bus: player inputs and control pulses in, judged round and scores out.
// The master side is the switch/key front end; the slave side is the referee.
interface rps_referee_if #(
    parameter int NUM_CHOICES = 3,
    parameter int IDX_W       = 4,
    parameter int SCORE_W     = 4
);
    logic                   choose;
    logic                   cont;
    logic                   reset_game;
    logic [NUM_CHOICES-1:0] p1_choice;
    logic [NUM_CHOICES-1:0] p2_choice;
    logic [IDX_W-1:0]       p1_idx;
    logic [IDX_W-1:0]       p2_idx;
    logic [1:0]             round_result;
    logic                   round_valid;
    logic [SCORE_W-1:0]     p1_score;
    logic [SCORE_W-1:0]     p2_score;
    logic                   match_over;
    logic [1:0]             match_winner;
    logic                   busy;

    modport master (
        output choose, cont, reset_game, p1_choice, p2_choice,
        input  p1_idx, p2_idx, round_result, round_valid,
               p1_score, p2_score, match_over, match_winner, busy
    );

    modport slave (
        input  choose, cont, reset_game, p1_choice, p2_choice,
        output p1_idx, p2_idx, round_result, round_valid,
               p1_score, p2_score, match_over, match_winner, busy
    );
endinterface

// File: rtl/rps_referee.sv
// N-way cyclic rock-paper-scissors referee. Latches one-hot choices, judges
// by cyclic dominance, keeps saturating scores and flags the match winner.
module rps_referee #(
    parameter int NUM_CHOICES = 3,
    parameter int WIN_SCORE   = 3,
    parameter int SCORE_W     = 4,
    parameter int IDX_W       = 4
) (
    input  logic         clk,
    input  logic         resetn,
    rps_referee_if.slave bus
);
    localparam logic [SCORE_W-1:0] WIN  = SCORE_W'(WIN_SCORE);
    localparam logic [IDX_W:0]     NC   = (IDX_W + 1)'(NUM_CHOICES);
    localparam logic [IDX_W:0]     HALF = (IDX_W + 1)'((NUM_CHOICES - 1) / 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_JUDGE,
        S_SHOW,
        S_OVER
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   p1_idx_q, p1_idx_d;
    logic [IDX_W-1:0]   p2_idx_q, p2_idx_d;
    logic [1:0]         result_q, result_d;
    logic               valid_q, valid_d;
    logic [SCORE_W-1:0] p1_score_q, p1_score_d;
    logic [SCORE_W-1:0] p2_score_q, p2_score_d;
    logic [1:0]         winner_q, winner_d;

    // One-hot to index; anything not exactly one-hot maps to choice 0.
    function automatic logic [IDX_W-1:0] decode(input logic [NUM_CHOICES-1:0] c);
        logic [IDX_W-1:0] idx;
        int               cnt;
        idx = '0;
        cnt = 0;
        for (int k = 0; k < NUM_CHOICES; k++) begin
            if (c[k]) begin
                idx = IDX_W'(k);
                cnt = cnt + 1;
            end
        end
        return (cnt == 1) ? idx : '0;
    endfunction

    // i beats j when the forward distance (j - i) mod N lies in 1..(N-1)/2.
    function automatic logic beats(input logic [IDX_W-1:0] i, input logic [IDX_W-1:0] j);
        logic [IDX_W:0] ie, je, d;
        ie = {1'b0, i};
        je = {1'b0, j};
        d  = (je >= ie) ? (je - ie) : (je + NC - ie);
        return (d != '0) && (d <= HALF);
    endfunction

    // Score increment that sticks at the winning score instead of wrapping.
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
        return (s >= WIN) ? s : s + 1'b1;
    endfunction

    // State and datapath registers; async reset clears everything.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            p1_idx_q   <= '0;
            p2_idx_q   <= '0;
            result_q   <= '0;
            valid_q    <= 1'b0;
            p1_score_q <= '0;
            p2_score_q <= '0;
            winner_q   <= '0;
        end else begin
            state_q    <= state_d;
            p1_idx_q   <= p1_idx_d;
            p2_idx_q   <= p2_idx_d;
            result_q   <= result_d;
            valid_q    <= valid_d;
            p1_score_q <= p1_score_d;
            p2_score_q <= p2_score_d;
            winner_q   <= winner_d;
        end
    end

    // Next-state and register updates; reset_game overrides every state.
    always_comb begin
        state_d    = state_q;
        p1_idx_d   = p1_idx_q;
        p2_idx_d   = p2_idx_q;
        result_d   = result_q;
        valid_d    = 1'b0;
        p1_score_d = p1_score_q;
        p2_score_d = p2_score_q;
        winner_d   = winner_q;
        if (bus.reset_game) begin
            state_d    = S_IDLE;
            result_d   = '0;
            p1_score_d = '0;
            p2_score_d = '0;
            winner_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.choose) state_d = S_DECODE;
                end
                S_DECODE: begin
                    p1_idx_d = decode(bus.p1_choice);
                    p2_idx_d = decode(bus.p2_choice);
                    state_d  = S_JUDGE;
                end
                S_JUDGE: begin
                    valid_d = 1'b1;
                    state_d = S_SHOW;
                    if (p1_idx_q == p2_idx_q) begin
                        result_d = 2'b00;
                    end else if (beats(p1_idx_q, p2_idx_q)) begin
                        result_d   = 2'b01;
                        p1_score_d = sat_inc(p1_score_q);
                        if (p1_score_d == WIN) begin
                            state_d  = S_OVER;
                            winner_d = 2'b01;
                        end
                    end else begin
                        result_d   = 2'b10;
                        p2_score_d = sat_inc(p2_score_q);
                        if (p2_score_d == WIN) begin
                            state_d  = S_OVER;
                            winner_d = 2'b10;
                        end
                    end
                end
                S_SHOW: begin
                    if (bus.cont) state_d = S_IDLE;
                end
                S_OVER: begin
                    state_d = S_OVER;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign bus.p1_idx       = p1_idx_q;
    assign bus.p2_idx       = p2_idx_q;
    assign bus.round_result = result_q;
    assign bus.round_valid  = valid_q;
    assign bus.p1_score     = p1_score_q;
    assign bus.p2_score     = p2_score_q;
    assign bus.match_winner = winner_q;
    assign bus.match_over   = (state_q == S_OVER);
    assign bus.busy         = (state_q != S_IDLE);
endmodule
